// File: rtl/fw_metadata_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : fw_metadata_streamer_if
// Description : Request/byte-stream bundle for the firmware metadata streamer.
//               master modport = streamer side, slave modport = requester /
//               byte-consumer side.
//   req              : one-cycle request to emit one metadata packet
//   tx_data/tx_valid : packet byte stream, held while not accepted
//   tx_ready         : consumer accepts the byte when tx_valid && tx_ready
//   busy             : packet in flight
//   done             : one-cycle pulse after the last byte is accepted
//   major/minor/patch: constant firmware version bytes
// Revision    : 1.0 - initial release
// ============================================================================
interface fw_metadata_streamer_if;
    logic       req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [7:0] major;
    logic [7:0] minor;
    logic [7:0] patch;

    modport master (
        input  req, tx_ready,
        output tx_data, tx_valid, busy, done, major, minor, patch
    );

    modport slave (
        output req, tx_ready,
        input  tx_data, tx_valid, busy, done, major, minor, patch
    );
endinterface
`default_nettype wire

// File: rtl/fw_metadata_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fw_metadata_streamer
// Description : Emits a 12-byte firmware metadata packet per request:
//               SYNC, LEN, SEQ, major, minor, patch, BUILD_ID (4, MSB first),
//               FLAGS, CHK (XOR of bytes 0-10). One request may be queued
//               while a packet is in flight; it follows back-to-back.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : fw_metadata_streamer_if.master (req, tx_*, busy, done, version)
// Revision    : 1.0 - initial release
// ============================================================================
module fw_metadata_streamer #(
    parameter logic [7:0]  FW_VER_MAJ   = 8'd11,
    parameter logic [7:0]  FW_VER_MIN   = 8'd0,
    parameter logic [7:0]  FW_VER_PATCH = 8'd1,
    parameter logic [31:0] BUILD_ID     = 32'h0000_0000,
    parameter logic [7:0]  FLAGS        = 8'h00,
    parameter logic [7:0]  SYNC         = 8'hA5
) (
    input  wire logic clk,
    input  wire logic reset,
    fw_metadata_streamer_if.master bus
);

    localparam logic [7:0] LEN       = 8'd10;
    localparam logic [3:0] LAST_IDX  = 4'd11;

    // Every byte except SEQ is constant, so the checksum is a constant
    // folded with the packet's SEQ value.
    localparam logic [7:0] CHK_BASE = SYNC ^ LEN ^ FW_VER_MAJ ^ FW_VER_MIN ^
                                      FW_VER_PATCH ^ BUILD_ID[31:24] ^
                                      BUILD_ID[23:16] ^ BUILD_ID[15:8] ^
                                      BUILD_ID[7:0] ^ FLAGS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] index;
    logic [7:0] seq;
    logic       pending;
    logic [7:0] data_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;

    function automatic logic [7:0] pkt_byte(input logic [3:0] i, input logic [7:0] s);
        logic [7:0] b;
        case (i)
            4'd0:    b = SYNC;
            4'd1:    b = LEN;
            4'd2:    b = s;
            4'd3:    b = FW_VER_MAJ;
            4'd4:    b = FW_VER_MIN;
            4'd5:    b = FW_VER_PATCH;
            4'd6:    b = BUILD_ID[31:24];
            4'd7:    b = BUILD_ID[23:16];
            4'd8:    b = BUILD_ID[15:8];
            4'd9:    b = BUILD_ID[7:0];
            4'd10:   b = FLAGS;
            4'd11:   b = CHK_BASE ^ s;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            index   <= 4'd0;
            seq     <= 8'd0;
            pending <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state   <= SEND;
                        index   <= 4'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        data_q  <= pkt_byte(4'd0, seq);
                    end
                end
                SEND: begin
                    // One-deep queue: further requests merge into the flag.
                    if (bus.req) begin
                        pending <= 1'b1;
                    end
                    if (bus.tx_ready) begin
                        if (index == LAST_IDX) begin
                            done_q  <= 1'b1;
                            seq     <= seq + 8'd1;
                            index   <= 4'd0;
                            pending <= 1'b0;
                            // A request on the final acceptance edge also
                            // counts as queued.
                            if (pending || bus.req) begin
                                data_q <= pkt_byte(4'd0, seq + 8'd1);
                            end else begin
                                state   <= IDLE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                data_q  <= 8'h00;
                            end
                        end else begin
                            index  <= index + 4'd1;
                            data_q <= pkt_byte(index + 4'd1, seq);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data  = data_q;
    assign bus.tx_valid = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.major    = FW_VER_MAJ;
    assign bus.minor    = FW_VER_MIN;
    assign bus.patch    = FW_VER_PATCH;

endmodule
`default_nettype wire

// File: tb/tb_fw_metadata_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fw_metadata_streamer
// Description : Self-checking bench for fw_metadata_streamer. Inputs change
//               and outputs are sampled on the falling edge. Expected bytes
//               come from a packet model built directly from the packet
//               layout and XOR checksum rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_metadata_streamer;

    logic clk;
    logic reset;

    fw_metadata_streamer_if bus1 ();
    fw_metadata_streamer_if bus2 ();

    fw_metadata_streamer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    fw_metadata_streamer #(
        .BUILD_ID (32'hDEAD_BEEF),
        .FLAGS    (8'h80)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_seq = 8'd0;
    logic [7:0] got [0:11];

    // Reference packet: layout table plus XOR of bytes 0-10.
    function automatic logic [7:0] model_byte(input logic [3:0] i, input logic [7:0] s,
                                              input logic [31:0] bid, input logic [7:0] flg);
        logic [7:0] p [0:11];
        p[0]  = 8'hA5;          p[1] = 8'd10;          p[2] = s;
        p[3]  = 8'd11;          p[4] = 8'd0;           p[5] = 8'd1;
        p[6]  = bid[31:24];     p[7] = bid[23:16];     p[8] = bid[15:8];
        p[9]  = bid[7:0];       p[10] = flg;           p[11] = 8'h00;
        for (int k = 0; k < 11; k++) p[11] = p[11] ^ p[k];
        return p[i];
    endfunction

    // Issue one request on bus1 and record the accepted bytes.
    task automatic capture(input bit rand_ready, output int nbytes, output int gaps,
                           output int stall_bad, output bit done_ok);
        logic       pv, pr;
        logic [7:0] pd;
        nbytes = 0; gaps = 0; stall_bad = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00;
        bus1.req = 1'b1;
        for (int cyc = 0; cyc < 400 && nbytes < 12; cyc++) begin
            @(negedge clk);
            bus1.req = 1'b0;
            if (pv && !pr && (bus1.tx_valid !== 1'b1 || bus1.tx_data !== pd)) stall_bad++;
            bus1.tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus1.tx_valid !== 1'b1 || bus1.busy !== 1'b1) gaps++;
            else if (bus1.tx_ready) begin
                got[nbytes] = bus1.tx_data;
                nbytes++;
            end
            pv = bus1.tx_valid; pr = bus1.tx_ready; pd = bus1.tx_data;
        end
        @(negedge clk);
        done_ok = (bus1.done === 1'b1) && (bus1.tx_valid === 1'b0) && (bus1.busy === 1'b0);
        bus1.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus1.req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus1.tx_valid !== 1'b0 || bus1.tx_data !== 8'h00 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b, want 0 00 0 0",
                     bus1.tx_valid, bus1.tx_data, bus1.busy, bus1.done);
        end
        checks++;
        if (bus1.major !== 8'd11 || bus1.minor !== 8'd0 || bus1.patch !== 8'd1) begin
            errors++;
            $display("FAIL version_ports: got %h.%h.%h, want 0b.00.01", bus1.major, bus1.minor, bus1.patch);
        end
        reset = 1'b0;
        bus1.req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus1.tx_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL req_during_reset: valid=%b busy=%b, want 0 0", bus1.tx_valid, bus1.busy);
        end
    endtask

    task automatic test_single();
        bus1.tx_ready = 1'b1;
        bus1.req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus1.req = 1'b0;
            checks++;
            if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== model_byte(4'(c), model_seq, 32'h0, 8'h00)) begin
                errors++;
                $display("FAIL single_byte%0d: valid=%b data=%h, want 1 %h", c, bus1.tx_valid,
                         bus1.tx_data, model_byte(4'(c), model_seq, 32'h0, 8'h00));
            end
        end
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b1 || bus1.tx_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b busy=%b, want 1 0 0", bus1.done, bus1.tx_valid, bus1.busy);
        end
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b0 || bus1.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b data=%h, want 0 00", bus1.done, bus1.tx_data);
        end
        model_seq = model_seq + 8'd1;
    endtask

    task automatic test_seq_wrap();
        int n, g, sb;
        bit dn;
        for (int k = 0; k < 258; k++) begin
            capture(k < 40, n, g, sb, dn);
            checks++;
            if (n != 12 || g != 0 || sb != 0 || !dn) begin
                errors++;
                $display("FAIL pkt%0d_framing: bytes=%0d gaps=%0d stall_bad=%0d done_ok=%0b, want 12 0 0 1",
                         k, n, g, sb, dn);
            end
            for (int b = 0; b < 12; b++) begin
                checks++;
                if (got[b] !== model_byte(4'(b), model_seq, 32'h0, 8'h00)) begin
                    errors++;
                    $display("FAIL pkt%0d_byte%0d: got %h, want %h", k, b, got[b],
                             model_byte(4'(b), model_seq, 32'h0, 8'h00));
                end
            end
            if (model_seq == 8'd1) begin
                checks++;
                if (got[2] !== 8'h01 || got[11] !== 8'hA4) begin
                    errors++;
                    $display("FAIL seq1_chk: seq=%h chk=%h, want 01 a4", got[2], got[11]);
                end
            end
            if (model_seq == 8'd0) begin
                checks++;
                if (got[2] !== 8'h00 || got[11] !== 8'hA5) begin
                    errors++;
                    $display("FAIL seq_wrap: seq=%h chk=%h, want 00 a5", got[2], got[11]);
                end
            end
            model_seq = model_seq + 8'd1;
        end
    endtask

    task automatic test_stall();
        int idx, stalled;
        idx = 0; stalled = 0;
        bus1.tx_ready = 1'b1;
        bus1.req = 1'b1;
        for (int cyc = 0; cyc < 40 && idx < 12; cyc++) begin
            @(negedge clk);
            bus1.req = 1'b0;
            if (idx == 3 && stalled < 5) begin
                bus1.tx_ready = 1'b0;
                stalled++;
            end else begin
                bus1.tx_ready = 1'b1;
            end
            checks++;
            if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== model_byte(4'(idx), model_seq, 32'h0, 8'h00)) begin
                errors++;
                $display("FAIL stall_idx%0d: valid=%b data=%h, want 1 %h", idx, bus1.tx_valid,
                         bus1.tx_data, model_byte(4'(idx), model_seq, 32'h0, 8'h00));
            end
            if (bus1.tx_ready) idx++;
        end
        @(negedge clk);
        checks++;
        if (idx != 12 || bus1.done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: bytes=%0d done=%b, want 12 1", idx, bus1.done);
        end
        model_seq = model_seq + 8'd1;
    endtask

    // req_mask bit c drives req on the negedge where cycle c is observed.
    task automatic test_pending(input logic [23:0] req_mask, input string name);
        logic [7:0] s;
        bus1.tx_ready = 1'b1;
        bus1.req = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            bus1.req = req_mask[c];
            s = (c < 12) ? model_seq : model_seq + 8'd1;
            checks++;
            if (bus1.tx_valid !== 1'b1 || bus1.busy !== 1'b1 ||
                bus1.tx_data !== model_byte(4'(c % 12), s, 32'h0, 8'h00) || bus1.done !== (c == 12)) begin
                errors++;
                $display("FAIL %s_cyc%0d: valid=%b busy=%b data=%h done=%b, want 1 1 %h %0b", name, c,
                         bus1.tx_valid, bus1.busy, bus1.tx_data, bus1.done,
                         model_byte(4'(c % 12), s, 32'h0, 8'h00), (c == 12));
            end
        end
        bus1.req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b1 || bus1.tx_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: done=%b valid=%b busy=%b, want 1 0 0", name, bus1.done, bus1.tx_valid, bus1.busy);
        end
        model_seq = model_seq + 8'd2;
    endtask

    task automatic test_reset_mid();
        int n, g, sb;
        bit dn;
        bus1.tx_ready = 1'b1;
        bus1.req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus1.req = 1'b0;
        end
        checks++;
        if (bus1.tx_data !== model_byte(4'd6, model_seq, 32'h0, 8'h00)) begin
            errors++;
            $display("FAIL abort_at_idx6: data=%h, want %h", bus1.tx_data, model_byte(4'd6, model_seq, 32'h0, 8'h00));
        end
        reset = 1'b1;
        bus1.req = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus1.req = 1'b0;
        checks++;
        if (bus1.tx_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_outputs: valid=%b busy=%b done=%b data=%h, want 0 0 0 00",
                     bus1.tx_valid, bus1.busy, bus1.done, bus1.tx_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.done !== 1'b0 || bus1.tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: done=%b valid=%b, want 0 0", c, bus1.done, bus1.tx_valid);
            end
        end
        model_seq = 8'd0;
        capture(1'b1, n, g, sb, dn);
        checks++;
        if (n != 12 || got[2] !== 8'h00 || got[11] !== model_byte(4'd11, 8'd0, 32'h0, 8'h00) || !dn) begin
            errors++;
            $display("FAIL post_abort_pkt: bytes=%0d seq=%h chk=%h done_ok=%0b, want 12 00 %h 1",
                     n, got[2], got[11], dn, model_byte(4'd11, 8'd0, 32'h0, 8'h00));
        end
        model_seq = model_seq + 8'd1;
    endtask

    task automatic test_build_id();
        bus2.tx_ready = 1'b1;
        bus2.req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus2.req = 1'b0;
            checks++;
            if (bus2.tx_valid !== 1'b1 || bus2.tx_data !== model_byte(4'(c), 8'd0, 32'hDEAD_BEEF, 8'h80)) begin
                errors++;
                $display("FAIL build_byte%0d: valid=%b data=%h, want 1 %h", c, bus2.tx_valid,
                         bus2.tx_data, model_byte(4'(c), 8'd0, 32'hDEAD_BEEF, 8'h80));
            end
        end
        @(negedge clk);
        checks++;
        if (bus2.done !== 1'b1) begin
            errors++;
            $display("FAIL build_done: done=%b, want 1", bus2.done);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus1.req = 1'b0; bus1.tx_ready = 1'b1;
        bus2.req = 1'b0; bus2.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_seq_wrap();
        test_stall();
        test_pending(24'h000124, "pending3");
        test_pending(24'h000800, "req_at_end");
        test_reset_mid();
        test_build_id();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fw_metadata_streamer.md
FW_METADATA_STREAMER -- requirements
Module: fw_metadata_streamer

Interface
REQ-001 SHALL have parameter FW_VER_MAJ, default 8'd11: firmware major version.
REQ-002 SHALL have parameter FW_VER_MIN, default 8'd0: firmware minor version.
REQ-003 SHALL have parameter FW_VER_PATCH, default 8'd1: firmware patch version.
REQ-004 SHALL have parameter BUILD_ID, default 32'h0000_0000: build identifier, sent MSB first.
REQ-005 SHALL have parameter FLAGS, default 8'h00: build-option flag byte.
REQ-006 SHALL have parameter SYNC, default 8'hA5: packet sync byte.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port req, input, 1: one-cycle request to emit one metadata packet.
REQ-010 SHALL have port tx_data, output, 8: current packet byte.
REQ-011 SHALL have port tx_valid, output, 1: tx_data valid.
REQ-012 SHALL have port tx_ready, input, 1: consumer accepts the byte when tx_valid && tx_ready.
REQ-013 SHALL have port busy, output, 1: high while a packet is in flight.
REQ-014 SHALL have port done, output, 1: one-cycle pulse after the last byte is accepted.
REQ-015 SHALL have ports major, minor, patch, output, 8 each: constant parameter values, combinational.

Function
REQ-016 SHALL emit a 12-byte packet in this index order: 0 SYNC; 1 LEN = 8'd10; 2 SEQ; 3 major; 4 minor; 5 patch; 6-9 BUILD_ID[31:24], [23:16], [15:8], [7:0]; 10 FLAGS; 11 CHK.
REQ-017 SHALL compute CHK as the bitwise XOR of bytes 0-10 of the same packet.
REQ-018 SHALL implement two states: IDLE and SEND.
REQ-019 SHALL transition IDLE->SEND on the edge where req=1; tx_valid=1 with index 0 on the next cycle (latency 1).
REQ-020 SHALL hold tx_data and tx_valid stable while tx_valid && !tx_ready (no bubbles inserted, no byte dropped).
REQ-021 SHALL advance the index by 1 on each accepted byte; tx_valid stays high between bytes (back-to-back at tx_ready=1 gives 12 consecutive cycles).
REQ-022 SHALL, when byte 11 is accepted, pulse done in the next cycle, increment SEQ modulo 256 (255->0), and go to IDLE unless a request is pending.
REQ-023 SHALL latch req asserted during SEND into a one-deep pending flag; additional requests while pending is set are discarded.
REQ-024 SHALL, when byte 11 is accepted with pending set, clear pending and restart at index 0 with the incremented SEQ; tx_valid stays high continuously.
REQ-025 SHALL treat req on the same edge as the final acceptance as pending (the follow-on packet is sent).
REQ-026 SHALL drive busy=1 in SEND and 0 in IDLE; tx_valid=0 and tx_data=8'h00 in IDLE.
REQ-027 SHALL use the SEQ value held at packet start for both byte 2 and CHK, regardless of pending requests.

Reset
REQ-028 SHALL, with reset=1 at a clock edge, force IDLE, index=0, SEQ=0, pending=0, tx_valid=0, tx_data=8'h00, busy=0, done=0.
REQ-029 SHALL abort a packet when reset is asserted mid-packet: no done pulse, no SEQ increment, no pending request survives.
REQ-030 SHALL ignore req while reset=1.

Verification
REQ-031 Defaults, tx_ready=1, one req pulse -> bytes A5 0A 00 0B 00 01 00 00 00 00 00 A5 on 12 consecutive cycles starting 1 cycle after req; done 1 cycle after the last byte.
REQ-032 Second req after done -> SEQ=01, CHK=A4; after 256 packets, SEQ wraps to 00.
REQ-033 tx_ready held 0 for 5 cycles at index 3 -> tx_data=0B stable with tx_valid=1 throughout; stream then resumes at index 4.
REQ-034 Three req pulses during one packet -> exactly one follow-on packet (SEQ+1), back-to-back with no tx_valid gap; busy high throughout.
REQ-035 reset at index 6 -> next cycle tx_valid=0 and busy=0; no done; following req emits SEQ=00.
REQ-036 BUILD_ID=32'hDEADBEEF, FLAGS=8'h80 -> bytes 6-10 are DE AD BE EF 80; CHK equals the XOR of bytes 0-10.
